spi_adc_responder: RTL
======================

// Module: spi_adc_responder
// PURPOSE
//  Behavioural-synthesizable SPI slave that emulates the 2-channel ADC read by the SPI ADC
//  controller (accel pedal on CH0, CdS light sensor on CH1), MCP3202 command/response format.
//  Used on the bench and in loopback builds in place of the physical ADC; drives SPI_DOUT.
//  Oversamples SCK/CS/MOSI in the system clock domain; channel values come from ports.
// PARAMETERS
//  DATA_W       12  conversion result width, shifted MSB first
//  SYNC_STAGES   2  flip-flop stages on spi_sck/spi_cs_n/spi_mosi before edge detect (>=2)
// PORTS
//  clk          in   1       system clock; only clock in the block
//  rst_n        in   1       asynchronous, active-low reset
//  spi_sck      in   1       SPI clock from master, idle low (mode 0,0)
//  spi_cs_n     in   1       chip select, active low; frame boundary
//  spi_mosi     in   1       command bits from master (start, SGL/DIFF, ODD/SIGN, MSBF)
//  spi_miso     out  1       response bits to master
//  spi_miso_oe  out  1       1 = spi_miso driven; 0 = top ties pad high-Z
//  ch0_val      in   DATA_W  value presented on CH0
//  ch1_val      in   DATA_W  value presented on CH1
//  frame_done   out  1       1-clk pulse: all DATA_W bits shifted out, frame complete
//  frame_err    out  1       1-clk pulse: CS rose before frame complete
//  last_cfg     out  3       {SGL, ODD, MSBF} of most recent accepted command
// BEHAVIOUR
//  Reset: spi_miso=1, spi_miso_oe=0, frame_done=0, frame_err=0, last_cfg=3'b100, FSM=IDLE.
//  Inputs pass SYNC_STAGES flops + 1 edge-detect flop; rise/fall events lag pins by
//  SYNC_STAGES+1 clk. Master SCK period must be >= 8 clk; both half-periods >= 4 clk.
//  Sample MOSI on sync SCK rise; update MISO on sync SCK fall (same clk as fall event).
//  FSM (shared-package encoding):
//   IDLE : oe=0. CS fall -> WAIT_START.
//   WAIT_START: oe=1, miso=1. SCK rise with MOSI=1 -> CMD, bit_cnt=0; MOSI=0 ignored (leading zeros).
//   CMD  : 3 SCK rises capture SGL, ODD, MSBF in order. On the rise capturing ODD, snapshot
//          result into shift reg (held stable for the frame). After MSBF rise -> NULL_BIT.
//   NULL_BIT: next SCK fall drives miso=0 -> DATA, bit_cnt=DATA_W-1.
//   DATA : each SCK fall drives result[bit_cnt], decrement; fall driving bit 0 -> DONE,
//          frame_done pulses on that clk, last_cfg updated on that clk.
//   DONE : further SCK falls drive miso=0 (no LSB-first repeat; MSBF stored only).
//  CS rise (sync) from any non-IDLE state -> IDLE next clk, oe=0; frame_err pulses if state
//   was WAIT_START..DATA with >=1 command bit captured; DONE->IDLE or WAIT_START with no
//   start bit: no error. CS rise takes priority over a same-clk SCK edge.
//  Result: SGL=1: ODD ? ch1_val : ch0_val. SGL=0 (diff): ODD=0 -> ch0-ch1, ODD=1 -> ch1-ch0,
//   computed DATA_W+1 bits wide, clipped to 0 when negative (never wraps).
//  ch*_val changes after the snapshot do not affect the frame in progress.
//  rst_n assertion mid-frame: immediate return to reset values; next frame requires a fresh CS fall.
//  frame_done and frame_err never assert on the same clk.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, WAIT_START, CMD, NULL_BIT, DATA, DONE),
//   command-bit index constants (CFG_SGL=2, CFG_ODD=1, CFG_MSBF=0), MIN_SCK_HALF_CLK=4.
//  One sub-module: spi_in_sync -- SYNC_STAGES synchronizer + edge detect for sck/cs_n/mosi,
//   outputs sck_rise, sck_fall, cs_fall, cs_rise, mosi_s. FSM and shift reg in top level.
// TESTING
//  1 Single-ended CH0: ch0=12'hA5C, cmd 1,1,0,1 -> null 0 then A5C MSB first; frame_done x1; last_cfg=3'b101.
//  2 Single-ended CH1 via real controller loopback: ch1=12'h7F0 -> controller adc_cds = 8'h7F.
//  3 Diff clip: ch0=12'h100, ch1=12'h300, SGL=0 ODD=0 -> 12'h000; ODD=1 -> 12'h200.
//  4 Leading zeros: 3 MOSI=0 clocks before start bit -> identical data to scenario 1.
//  5 Abort: CS rise after 5 data bits -> frame_err x1, oe=0 within SYNC_STAGES+2 clk; next frame correct.
//  6 Snapshot/reset: change ch0 mid-DATA -> old value shifted; rst_n low mid-frame -> oe=0, miso=1 at once.

Source files
------------

// File: rtl/spi_adc_responder_pkg.sv
// Shared definitions for the SPI ADC responder: FSM encoding, command-bit
// positions inside last_cfg, and SCK timing limits.
package spi_adc_responder_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitStart = 3'd1,
    StCmd       = 3'd2,
    StNullBit   = 3'd3,
    StData      = 3'd4,
    StDone      = 3'd5
  } state_e;

  // Bit positions of the command fields inside {SGL, ODD, MSBF}
  localparam int unsigned CFG_SGL  = 2;
  localparam int unsigned CFG_ODD  = 1;
  localparam int unsigned CFG_MSBF = 0;

  // Single-ended CH0, MSB first: value of last_cfg before any command
  localparam logic [2:0] CFG_RESET = 3'b100;

  // Shortest SCK half-period (in clk cycles) the oversampler resolves reliably
  localparam int unsigned MIN_SCK_HALF_CLK = 4;

  // True while a frame has consumed at least one command bit but not finished
  function automatic logic frame_open(input state_e st);
    return (st == StCmd) || (st == StNullBit) || (st == StData);
  endfunction

endpackage

// File: rtl/spi_adc_responder_in_sync.sv
// Synchronizes SCK/CS_N/MOSI into the clk domain and detects their edges.
// Edge pulses appear SYNC_STAGES clk after the pin change and are consumed
// on the following clk edge.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  // Synchronizer chains plus one history flop per edge-detected line; reset
  // values match the idle bus (SCK low, CS deasserted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge events from the synchronized level versus its previous value
  always_comb begin
    sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/spi_adc_responder.sv
// MCP3202-style SPI slave emulating a 2-channel ADC. All SPI pins are
// oversampled in the clk domain; channel values come from ports and are
// snapshotted once per frame.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] ch0_val,
  input  logic [DATA_W-1:0] ch1_val,
  output logic              frame_done,
  output logic              frame_err,
  output logic [2:0]        last_cfg
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_sck (spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise),
    .mosi_s  (mosi_s)
  );

  // Differential results are formed one bit wider so a negative difference
  // is detected and clipped to zero instead of wrapping.
  function automatic logic [DATA_W-1:0] select_result(
    input logic              sgl,
    input logic              odd,
    input logic [DATA_W-1:0] c0,
    input logic [DATA_W-1:0] c1
  );
    logic [DATA_W:0] diff;
    diff = odd ? ({1'b0, c1} - {1'b0, c0}) : ({1'b0, c0} - {1'b0, c1});
    if (sgl) begin
      return odd ? c1 : c0;
    end
    return diff[DATA_W] ? '0 : diff[DATA_W-1:0];
  endfunction

  state_e            state_q;
  logic [1:0]        cmd_cnt_q;
  logic [2:0]        cfg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;

  // Frame FSM with registered MISO/OE/status outputs; CS rise overrides any
  // SCK edge seen on the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_cnt_q   <= '0;
      cfg_q       <= CFG_RESET;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      last_cfg    <= CFG_RESET;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if ((state_q != StIdle) && cs_rise) begin
        state_q     <= StIdle;
        spi_miso    <= 1'b1;
        spi_miso_oe <= 1'b0;
        frame_err   <= frame_open(state_q);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q     <= StWaitStart;
              spi_miso    <= 1'b1;
              spi_miso_oe <= 1'b1;
            end
          end
          StWaitStart: begin
            // Leading zeros before the start bit are ignored
            if (sck_rise && mosi_s) begin
              state_q   <= StCmd;
              cmd_cnt_q <= '0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              cmd_cnt_q <= cmd_cnt_q + 2'd1;
              case (cmd_cnt_q)
                2'd0: cfg_q[CFG_SGL] <= mosi_s;
                2'd1: begin
                  cfg_q[CFG_ODD] <= mosi_s;
                  shift_q <= select_result(cfg_q[CFG_SGL], mosi_s, ch0_val, ch1_val);
                end
                default: begin
                  cfg_q[CFG_MSBF] <= mosi_s;
                  state_q         <= StNullBit;
                end
              endcase
            end
          end
          StNullBit: begin
            if (sck_fall) begin
              spi_miso  <= 1'b0;
              bit_cnt_q <= CNT_W'(DATA_W - 1);
              state_q   <= StData;
            end
          end
          StData: begin
            if (sck_fall) begin
              spi_miso <= shift_q[bit_cnt_q];
              if (bit_cnt_q == '0) begin
                state_q    <= StDone;
                frame_done <= 1'b1;
                last_cfg   <= cfg_q;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
              end
            end
          end
          StDone: begin
            // Only MSB-first is supported: no LSB-first replay
            if (sck_fall) spi_miso <= 1'b0;
          end
          default: begin
            state_q     <= StIdle;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
